// File: rtl/station_dest_tracker.sv
// Destination tracker downstream of the barcode decoder: compares decoded station
// IDs against the host-commanded destination, counts stations and flags timeouts.
module station_dest_tracker #(
  parameter int unsigned TMO_CYC = 50_000_000,
  parameter int unsigned TMO_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dest_vld,
  input  logic [5:0] dest_ID,
  input  logic       abort,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  output logic       clr_ID_vld,
  output logic       in_transit,
  output logic       at_dest,
  output logic       tmo_err,
  output logic [7:0] stn_cnt,
  output logic [5:0] last_ID
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  logic [TMO_W-1:0] r_timer;
  logic [5:0]       r_dest;
  logic             r_id_vld_q;
  logic [7:0]       r_id_q;
  logic             r_clr;
  logic             r_in_transit;
  logic             r_at_dest;
  logic             r_tmo_err;
  logic [7:0]       r_stn_cnt;
  logic [5:0]       r_last_id;

  state_t w_nxt;
  logic   w_id_edge;
  logic   w_tmo;
  logic   w_id_ok;
  logic   w_ctl;

  assign w_id_edge = ID_vld & ~r_id_vld_q;
  assign w_tmo     = (r_timer == TMO_LAST);
  assign w_id_ok   = (r_id_q[7:6] == 2'b00);
  // abort and dest_vld pre-empt every state-local action
  assign w_ctl     = abort | dest_vld;

  always_comb begin
    w_nxt = r_state;
    if (abort) begin
      w_nxt = S_IDLE;
    end else if (dest_vld) begin
      w_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_id_edge)  w_nxt = S_CHECK;
          else if (w_tmo) w_nxt = S_IDLE;
        end
        S_CHECK: w_nxt = (w_id_ok && (r_id_q[5:0] == r_dest)) ? S_DONE : S_ARMED;
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_dest       <= '0;
      r_id_vld_q   <= 1'b0;
      r_id_q       <= '0;
      r_clr        <= 1'b0;
      r_in_transit <= 1'b0;
      r_at_dest    <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_stn_cnt    <= '0;
      r_last_id    <= '0;
    end else begin
      r_state      <= w_nxt;
      r_id_vld_q   <= ID_vld;
      if (w_id_edge) r_id_q <= ID;
      // DONE still acknowledges IDs to the decoder without counting them
      r_clr        <= (w_nxt == S_CHECK) |
                      ((r_state == S_DONE) & w_id_edge & ~w_ctl);
      r_in_transit <= (w_nxt == S_ARMED) | (w_nxt == S_CHECK);
      r_at_dest    <= (w_nxt == S_DONE);

      if (!abort && dest_vld) begin
        r_dest    <= dest_ID;
        r_stn_cnt <= '0;
        r_timer   <= '0;
        r_tmo_err <= 1'b0;
      end else if (!abort) begin
        case (r_state)
          S_ARMED: begin
            r_timer <= r_timer + TMO_W'(1);
            if (!w_id_edge && w_tmo) r_tmo_err <= 1'b1;
          end
          S_CHECK: begin
            r_timer <= '0;
            if (w_id_ok) begin
              if (r_stn_cnt != 8'hFF) r_stn_cnt <= r_stn_cnt + 8'd1;
              r_last_id <= r_id_q[5:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign clr_ID_vld = r_clr;
  assign in_transit = r_in_transit;
  assign at_dest    = r_at_dest;
  assign tmo_err    = r_tmo_err;
  assign stn_cnt    = r_stn_cnt;
  assign last_ID    = r_last_id;

endmodule

// File: tb/tb_station_dest_tracker.sv
// Self-checking bench for station_dest_tracker: vector table for the trip flow,
// plus directed sequences for held ID_vld, timeout and counter saturation.
module tb_station_dest_tracker;

  localparam int unsigned TMO_CYC = 100;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned NVEC    = 19;

  logic       clk = 1'b0;
  logic       rst;
  logic       dest_vld;
  logic [5:0] dest_ID;
  logic       abort;
  logic       ID_vld;
  logic [7:0] ID;
  logic       clr_ID_vld;
  logic       in_transit;
  logic       at_dest;
  logic       tmo_err;
  logic [7:0] stn_cnt;
  logic [5:0] last_ID;

  int n_chk  = 0;
  int n_fail = 0;

  station_dest_tracker #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .dest_vld  (dest_vld),
    .dest_ID   (dest_ID),
    .abort     (abort),
    .ID_vld    (ID_vld),
    .ID        (ID),
    .clr_ID_vld(clr_ID_vld),
    .in_transit(in_transit),
    .at_dest   (at_dest),
    .tmo_err   (tmo_err),
    .stn_cnt   (stn_cnt),
    .last_ID   (last_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [5:0] did;
    logic       ab;
    logic       iv;
    logic [7:0] id;
    logic       e_clr;
    logic       e_it;
    logic       e_ad;
    logic       e_tmo;
    logic [7:0] e_cnt;
    logic [5:0] e_last;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic dv, logic [5:0] did, logic ab, logic iv, logic [7:0] id,
                              logic e_clr, logic e_it, logic e_ad, logic e_tmo,
                              logic [7:0] e_cnt, logic [5:0] e_last);
    vec_t v;
    v.dv = dv; v.did = did; v.ab = ab; v.iv = iv; v.id = id;
    v.e_clr = e_clr; v.e_it = e_it; v.e_ad = e_ad; v.e_tmo = e_tmo;
    v.e_cnt = e_cnt; v.e_last = e_last;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    dest_vld = vecs[i].dv;
    dest_ID  = vecs[i].did;
    abort    = vecs[i].ab;
    ID_vld   = vecs[i].iv;
    ID       = vecs[i].id;
    tick();
    chk($sformatf("v%0d clr_ID_vld", i), 32'(clr_ID_vld), 32'(vecs[i].e_clr));
    chk($sformatf("v%0d in_transit", i), 32'(in_transit), 32'(vecs[i].e_it));
    chk($sformatf("v%0d at_dest", i),    32'(at_dest),    32'(vecs[i].e_ad));
    chk($sformatf("v%0d tmo_err", i),    32'(tmo_err),    32'(vecs[i].e_tmo));
    chk($sformatf("v%0d stn_cnt", i),    32'(stn_cnt),    32'(vecs[i].e_cnt));
    chk($sformatf("v%0d last_ID", i),    32'(last_ID),    32'(vecs[i].e_last));
  endtask

  initial begin
    int n;
    // dv did ab iv id | clr it ad tmo cnt last
    vecs[0]  = mk(1, 6'd5, 0, 0, 8'h00, 0, 1, 0, 0, 8'd0, 6'd0);
    vecs[1]  = mk(0, 6'd0, 0, 1, 8'h03, 1, 1, 0, 0, 8'd0, 6'd0);
    vecs[2]  = mk(0, 6'd0, 0, 0, 8'h03, 0, 1, 0, 0, 8'd1, 6'd3);
    vecs[3]  = mk(0, 6'd0, 0, 1, 8'h09, 1, 1, 0, 0, 8'd1, 6'd3);
    vecs[4]  = mk(0, 6'd0, 0, 0, 8'h09, 0, 1, 0, 0, 8'd2, 6'd9);
    vecs[5]  = mk(0, 6'd0, 0, 1, 8'h05, 1, 1, 0, 0, 8'd2, 6'd9);
    vecs[6]  = mk(0, 6'd0, 0, 1, 8'h05, 0, 0, 1, 0, 8'd3, 6'd5);
    vecs[7]  = mk(0, 6'd0, 0, 0, 8'h05, 0, 0, 1, 0, 8'd3, 6'd5);
    vecs[8]  = mk(0, 6'd0, 0, 1, 8'h07, 1, 0, 1, 0, 8'd3, 6'd5);
    vecs[9]  = mk(0, 6'd0, 0, 0, 8'h07, 0, 0, 1, 0, 8'd3, 6'd5);
    vecs[10] = mk(1, 6'd5, 0, 0, 8'h00, 0, 1, 0, 0, 8'd0, 6'd5);
    vecs[11] = mk(0, 6'd0, 0, 1, 8'hC5, 1, 1, 0, 0, 8'd0, 6'd5);
    vecs[12] = mk(0, 6'd0, 0, 0, 8'hC5, 0, 1, 0, 0, 8'd0, 6'd5);
    vecs[13] = mk(1, 6'd2, 1, 0, 8'h00, 0, 0, 0, 0, 8'd0, 6'd5);
    vecs[14] = mk(1, 6'd2, 0, 0, 8'h00, 0, 1, 0, 0, 8'd0, 6'd5);
    vecs[15] = mk(0, 6'd0, 0, 1, 8'h01, 1, 1, 0, 0, 8'd0, 6'd5);
    vecs[16] = mk(0, 6'd0, 1, 0, 8'h01, 0, 0, 0, 0, 8'd0, 6'd5);
    vecs[17] = mk(0, 6'd0, 0, 1, 8'h02, 0, 0, 0, 0, 8'd0, 6'd5);
    vecs[18] = mk(0, 6'd0, 0, 0, 8'h02, 0, 0, 0, 0, 8'd0, 6'd5);

    rst = 1'b1; dest_vld = 1'b0; dest_ID = '0; abort = 1'b0; ID_vld = 1'b0; ID = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst clr_ID_vld", 32'(clr_ID_vld), 32'd0);
    chk("rst in_transit", 32'(in_transit), 32'd0);
    chk("rst at_dest",    32'(at_dest),    32'd0);
    chk("rst tmo_err",    32'(tmo_err),    32'd0);
    chk("rst stn_cnt",    32'(stn_cnt),    32'd0);
    chk("rst last_ID",    32'(last_ID),    32'd0);

    // ID pulses while IDLE must not be acknowledged
    for (int p = 0; p < 3; p++) begin
      ID_vld = 1'b1; ID = 8'(p + 1);
      tick(); chk("idle clr hi", 32'(clr_ID_vld), 32'd0);
      ID_vld = 1'b0;
      tick(); chk("idle clr lo", 32'(clr_ID_vld), 32'd0);
    end

    for (int i = 0; i < int'(NVEC); i++) apply_vec(i);

    // ID_vld held high for 20 cycles is a single event
    dest_vld = 1'b1; dest_ID = 6'd10; tick(); dest_vld = 1'b0;
    ID = 8'h04; ID_vld = 1'b1; n = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (clr_ID_vld) n++; end
    ID_vld = 1'b0; tick(); if (clr_ID_vld) n++;
    chk("held clr pulses", 32'(n), 32'd1);
    chk("held stn_cnt",    32'(stn_cnt), 32'd1);
    chk("held last_ID",    32'(last_ID), 32'd4);

    // timeout after exactly TMO_CYC ARMED cycles
    dest_ID = 6'd5; dest_vld = 1'b1; tick(); dest_vld = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (!in_transit) break;
      n++;
      tick();
    end
    chk("tmo armed cycles", 32'(n), 32'(TMO_CYC));
    chk("tmo tmo_err",      32'(tmo_err), 32'd1);
    chk("tmo in_transit",   32'(in_transit), 32'd0);
    dest_vld = 1'b1; tick(); dest_vld = 1'b0;
    chk("retarget tmo_err",    32'(tmo_err), 32'd0);
    chk("retarget in_transit", 32'(in_transit), 32'd1);

    // ID edge on the timeout cycle wins
    for (int c = 0; c < int'(TMO_CYC) - 1; c++) tick();
    ID = 8'h01; ID_vld = 1'b1; tick();
    chk("race clr_ID_vld", 32'(clr_ID_vld), 32'd1);
    chk("race tmo_err",    32'(tmo_err), 32'd0);
    ID_vld = 1'b0; tick();
    chk("race in_transit", 32'(in_transit), 32'd1);
    chk("race stn_cnt",    32'(stn_cnt), 32'd1);

    // station count saturates at 8'hFF
    dest_ID = 6'd63; dest_vld = 1'b1; tick(); dest_vld = 1'b0;
    for (int k = 0; k < 258; k++) begin
      ID = 8'(k % 63); ID_vld = 1'b1; tick();
      ID_vld = 1'b0; tick();
    end
    chk("sat stn_cnt",    32'(stn_cnt), 32'hFF);
    chk("sat last_ID",    32'(last_ID), 32'd5);
    chk("sat in_transit", 32'(in_transit), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort in_transit", 32'(in_transit), 32'd0);
    chk("abort stn_cnt",    32'(stn_cnt), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
